// File: rtl/alu_gcd_sequencer.sv
// Euclid GCD controller driving an external ALU: orders the operands with the
// bigger/smaller modes, then iterates modulo operations until the remainder is 0.
module alu_gcd_sequencer #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ITER_W         = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] zahl_a_i,
  input  logic [DATA_W-1:0] zahl_b_i,
  output logic [2:0]        alu_mode_o,
  output logic              modulo_start_o,
  output logic [DATA_W-1:0] op_a_o,
  output logic [DATA_W-1:0] op_b_o,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic              modulo_ready_i,
  output logic [DATA_W-1:0] ergebnis_o,
  output logic              valid_o,
  output logic              error_o,
  output logic              busy_o,
  output logic [ITER_W-1:0] iter_cnt_o
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ORD_BIG   = 3'd1;
  localparam logic [2:0] S_ORD_SMALL = 3'd2;
  localparam logic [2:0] S_CHECK     = 3'd3;
  localparam logic [2:0] S_MOD_START = 3'd4;
  localparam logic [2:0] S_MOD_WAIT  = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam logic [2:0] MODE_BIG   = 3'd0;
  localparam logic [2:0] MODE_SMALL = 3'd1;
  localparam logic [2:0] MODE_MOD   = 3'd2;
  localparam logic [2:0] MODE_IDLE  = 3'd3;

  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ITER_W-1:0] ITER_MAX = '1;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] big_q, big_d;
  logic [DATA_W-1:0] small_q, small_d;
  logic [DATA_W-1:0] ergebnis_q, ergebnis_d;
  logic              error_q, error_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    big_d      = big_q;
    small_d    = small_q;
    ergebnis_d = ergebnis_q;
    error_d    = error_q;
    tmo_d      = tmo_q;
    iter_d     = iter_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d        = zahl_a_i;
          b_d        = zahl_b_i;
          ergebnis_d = '0;
          error_d    = 1'b0;
          iter_d     = '0;
          state_d    = S_ORD_BIG;
        end
      end
      S_ORD_BIG: begin
        big_d   = alu_res_i;
        state_d = S_ORD_SMALL;
      end
      S_ORD_SMALL: begin
        small_d = alu_res_i;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        a_d = big_q;
        b_d = small_q;
        if (small_q == '0) begin
          ergebnis_d = big_q;
          state_d    = S_DONE;
        end else begin
          state_d = S_MOD_START;
        end
      end
      S_MOD_START: begin
        tmo_d   = '0;
        state_d = S_MOD_WAIT;
      end
      S_MOD_WAIT: begin
        // Ready is only looked at here, so a level left over from the
        // previous operation cannot be mistaken for the current result.
        if (modulo_ready_i) begin
          a_d = b_q;
          b_d = alu_res_i;
          if (iter_q != ITER_MAX) iter_d = iter_q + 1'b1;
          if (alu_res_i == '0) begin
            ergebnis_d = b_q;
            state_d    = S_DONE;
          end else begin
            state_d = S_MOD_START;
          end
        end else if (tmo_q == TMO_LAST) begin
          error_d    = 1'b1;
          ergebnis_d = '0;
          state_d    = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      big_q      <= '0;
      small_q    <= '0;
      ergebnis_q <= '0;
      error_q    <= 1'b0;
      tmo_q      <= '0;
      iter_q     <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      big_q      <= big_d;
      small_q    <= small_d;
      ergebnis_q <= ergebnis_d;
      error_q    <= error_d;
      tmo_q      <= tmo_d;
      iter_q     <= iter_d;
    end
  end

  always_comb begin
    case (state_q)
      S_ORD_BIG:   alu_mode_o = MODE_BIG;
      S_ORD_SMALL: alu_mode_o = MODE_SMALL;
      S_MOD_START: alu_mode_o = MODE_MOD;
      S_MOD_WAIT:  alu_mode_o = MODE_MOD;
      default:     alu_mode_o = MODE_IDLE;
    endcase
  end

  assign op_a_o         = a_q;
  assign op_b_o         = b_q;
  assign modulo_start_o = (state_q == S_MOD_START);
  assign valid_o        = (state_q == S_DONE);
  assign busy_o         = (state_q != S_IDLE);
  assign ergebnis_o     = ergebnis_q;
  assign error_o        = error_q;
  assign iter_cnt_o     = iter_q;

endmodule

// File: tb/tb_alu_gcd_sequencer.sv
// Bench for alu_gcd_sequencer: behavioural ALU with a variable-latency modulo
// unit, and a plain-arithmetic Euclid reference for the expected results.
module tb_alu_gcd_sequencer;
  localparam int DATA_W = 16;
  localparam int TMO    = 16;
  localparam int ITER_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [DATA_W-1:0] zahl_a_i, zahl_b_i;
  logic [2:0]        alu_mode_o;
  logic              modulo_start_o;
  logic [DATA_W-1:0] op_a_o, op_b_o;
  logic [DATA_W-1:0] alu_res_i;
  logic              modulo_ready_i;
  logic [DATA_W-1:0] ergebnis_o;
  logic              valid_o, error_o, busy_o;
  logic [ITER_W-1:0] iter_cnt_o;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q[$];

  // ALU environment controls
  int mod_fixed = 0;
  bit hang = 1'b0;
  logic [DATA_W-1:0] rem_q = '0;
  logic              rdy_q = 1'b0;
  int                cnt_q = 0;

  alu_gcd_sequencer #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .zahl_a_i(zahl_a_i), .zahl_b_i(zahl_b_i),
    .alu_mode_o(alu_mode_o), .modulo_start_o(modulo_start_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .alu_res_i(alu_res_i), .modulo_ready_i(modulo_ready_i), .ergebnis_o(ergebnis_o),
    .valid_o(valid_o), .error_o(error_o), .busy_o(busy_o), .iter_cnt_o(iter_cnt_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural ALU: combinational compare modes, multi-cycle modulo unit
  always @(posedge clk) begin
    if (modulo_start_o) begin
      rem_q <= (op_b_o == '0) ? '0 : op_a_o % op_b_o;
      rdy_q <= 1'b0;
      cnt_q <= (mod_fixed != 0) ? mod_fixed : int'($urandom_range(1, 6));
    end else if (cnt_q > 0) begin
      cnt_q <= cnt_q - 1;
      if (cnt_q == 1 && !hang) rdy_q <= 1'b1;
    end
  end
  assign modulo_ready_i = rdy_q;

  always_comb begin
    case (alu_mode_o)
      3'd0:    alu_res_i = (op_a_o > op_b_o) ? op_a_o : op_b_o;
      3'd1:    alu_res_i = (op_a_o < op_b_o) ? op_a_o : op_b_o;
      3'd2:    alu_res_i = rem_q;
      default: alu_res_i = '0;
    endcase
  end

  // reference: Euclid with plain arithmetic
  function automatic void ref_gcd(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                  output logic [DATA_W-1:0] g, output int iters);
    logic [DATA_W-1:0] a, b, r;
    a = (x > y) ? x : y;
    b = (x > y) ? y : x;
    iters = 0;
    while (b != 0) begin
      r = a % b;
      a = b;
      b = r;
      iters++;
    end
    g = a;
    if (iters > (1 << ITER_W) - 1) iters = (1 << ITER_W) - 1;
  endfunction

  // driver: issue one start, wait for valid; lat counts cycles after the accepting edge
  task automatic run_gcd(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y, input bit noise,
                         output int lat, output int pulses);
    bit got;
    @(negedge clk);
    zahl_a_i = x;
    zahl_b_i = y;
    start_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    got = 1'b0;
    lat = 0;
    pulses = 0;
    for (int c = 1; c <= 2000 && !got; c++) begin
      if (modulo_start_o) pulses++;
      if (valid_o) begin
        got = 1'b1;
        lat = c;
      end else begin
        if (noise) begin
          start_i  = 1'($urandom_range(0, 1));
          zahl_a_i = DATA_W'($urandom);
          zahl_b_i = DATA_W'($urandom);
        end
        @(negedge clk);
      end
    end
    start_i = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL valid_timeout: a=%0d b=%0d no valid_o within 2000 cycles", x, y);
    end
  endtask

  // checks one finished run against the reference and the one-cycle valid pulse
  task automatic check_run(input string tag, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                           input bit noise);
    logic [DATA_W-1:0] g;
    int it, lat, pulses;
    ref_gcd(x, y, g, it);
    exp_q.push_back(g);
    run_gcd(x, y, noise, lat, pulses);
    g = exp_q.pop_front();
    checks++;
    if (ergebnis_o !== g) begin
      errors++;
      $display("FAIL %s_result: got %0d expected %0d", tag, ergebnis_o, g);
    end
    checks++;
    if (iter_cnt_o !== ITER_W'(it)) begin
      errors++;
      $display("FAIL %s_iter: got %0d expected %0d", tag, iter_cnt_o, it);
    end
    checks++;
    if (pulses != it) begin
      errors++;
      $display("FAIL %s_mod_starts: got %0d expected %0d", tag, pulses, it);
    end
    checks++;
    if (error_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_error: got %0b expected 0", tag, error_o);
    end
    if (it == 0) begin
      checks++;
      if (lat != 4) begin
        errors++;
        $display("FAIL %s_latency: got %0d expected 4", tag, lat);
      end
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || ergebnis_o !== g) begin
      errors++;
      $display("FAIL %s_after: valid=%0b busy=%0b res=%0d expected 0 0 %0d",
               tag, valid_o, busy_o, ergebnis_o, g);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b0;
    zahl_a_i = '0;
    zahl_b_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (alu_mode_o !== 3'd3 || modulo_start_o !== 1'b0 || op_a_o !== '0 || op_b_o !== '0 ||
        ergebnis_o !== '0 || valid_o !== 1'b0 || error_o !== 1'b0 || busy_o !== 1'b0 ||
        iter_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_values: mode=%0d ms=%0b a=%0d b=%0d res=%0d v=%0b e=%0b busy=%0b it=%0d expected mode=3 rest 0",
               alu_mode_o, modulo_start_o, op_a_o, op_b_o, ergebnis_o, valid_o, error_o, busy_o, iter_cnt_o);
    end
  endtask

  task automatic test_directed();
    check_run("gcd_48_18", 16'd48, 16'd18, 1'b0);
    check_run("gcd_18_48", 16'd18, 16'd48, 1'b0);
    check_run("gcd_0_0", 16'd0, 16'd0, 1'b0);
    check_run("gcd_17_0", 16'd17, 16'd0, 1'b0);
    check_run("gcd_0_9", 16'd0, 16'd9, 1'b0);
    check_run("gcd_equal", 16'd300, 16'd300, 1'b0);
  endtask

  task automatic test_busy_start_ignored();
    check_run("gcd_max", 16'd65535, 16'd65534, 1'b1);
    check_run("gcd_noise", 16'd1071, 16'd462, 1'b1);
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] x, y;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        x = DATA_W'($urandom);
        y = DATA_W'($urandom);
      end else begin
        x = DATA_W'($urandom_range(0, 60)) * 16'd7;
        y = DATA_W'($urandom_range(0, 60)) * 16'd7;
      end
      check_run("gcd_random", x, y, i[2]);
    end
  endtask

  task automatic test_timeout();
    int lat, pulses;
    hang = 1'b1;
    run_gcd(16'd100, 16'd30, 1'b0, lat, pulses);
    hang = 1'b0;
    checks++;
    if (error_o !== 1'b1 || ergebnis_o !== '0) begin
      errors++;
      $display("FAIL timeout_flags: error=%0b res=%0d expected 1 0", error_o, ergebnis_o);
    end
    // ORD_BIG, ORD_SMALL, CHECK, MOD_START, TMO cycles of MOD_WAIT, then DONE
    checks++;
    if (lat != 5 + TMO) begin
      errors++;
      $display("FAIL timeout_latency: got %0d expected %0d", lat, 5 + TMO);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL timeout_mod_starts: got %0d expected 1", pulses);
    end
    repeat (3) @(negedge clk);
    check_run("after_timeout", 16'd12, 16'd8, 1'b0);
  endtask

  task automatic test_reset_in_mod_wait();
    bit seen, bad;
    mod_fixed = 4;
    @(negedge clk);
    zahl_a_i = 16'd48;
    zahl_b_i = 16'd18;
    start_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (modulo_start_o) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_wait_start: no modulo_start_o within 50 cycles");
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || alu_mode_o !== 3'd3 || modulo_start_o !== 1'b0 || op_a_o !== '0 ||
        op_b_o !== '0 || ergebnis_o !== '0 || valid_o !== 1'b0 || error_o !== 1'b0 ||
        iter_cnt_o !== '0) begin
      errors++;
      $display("FAIL rst_mod_wait: busy=%0b mode=%0d ms=%0b a=%0d b=%0d res=%0d v=%0b e=%0b it=%0d expected busy 0 mode 3 rest 0",
               busy_o, alu_mode_o, modulo_start_o, op_a_o, op_b_o, ergebnis_o, valid_o, error_o, iter_cnt_o);
    end
    bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy_o !== 1'b0 || valid_o !== 1'b0 || modulo_start_o !== 1'b0 || alu_mode_o !== 3'd3) bad = 1'b1;
    end
    checks++;
    if (bad || modulo_ready_i !== 1'b1) begin
      errors++;
      $display("FAIL late_ready_idle: state changed=%0b ready=%0b expected 0 1", bad, modulo_ready_i);
    end
    mod_fixed = 0;
    check_run("after_reset", 16'd48, 16'd18, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_start_ignored();
    test_random();
    test_timeout();
    test_reset_in_mod_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_gcd_sequencer.md
Name: alu_gcd_sequencer

Overview:
- Initiator-side controller for the ALU datapath. It drives the ALU's mode, modulo-start and operand inputs, and consumes the ALU's result and modulo-ready outputs.
- Computes the greatest common divisor of two 16-bit numbers by Euclid's algorithm: ALU "bigger/smaller" modes order the operands, then repeated ALU modulo operations run until the remainder is 0.
- Sits between the top-level control and the ALU instance; the ALU and its modulo unit are unchanged.

Parameters:
- DATA_W, 16, operand/result width; must match the ALU.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in MOD_WAIT per modulo operation before aborting.
- ITER_W, 6, width of the iteration counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  start request; sampled only in IDLE.
- zahl_a_i  in  DATA_W  first operand; captured when start is accepted.
- zahl_b_i  in  DATA_W  second operand; captured when start is accepted.
- alu_mode_o  out  3  ALU mode: 0 = bigger, 1 = smaller, 2 = modulo, 3 = idle.
- modulo_start_o  out  1  one-cycle start pulse to the ALU modulo unit.
- op_a_o  out  DATA_W  ALU operand A.
- op_b_o  out  DATA_W  ALU operand B.
- alu_res_i  in  DATA_W  ALU result (combinational from the ALU).
- modulo_ready_i  in  1  ALU modulo-ready.
- ergebnis_o  out  DATA_W  GCD result; held until the next start is accepted.
- valid_o  out  1  one-cycle pulse when the result is ready.
- error_o  out  1  set with valid_o on timeout; cleared on the next accepted start.
- busy_o  out  1  high in every state except IDLE.
- iter_cnt_o  out  ITER_W  number of modulo operations completed; saturates at its maximum.

Behaviour:
- Reset values: all outputs 0 except alu_mode_o = 3. The FSM goes to IDLE. Registers A, B, the timeout counter and the iteration counter are cleared.
- Reset takes priority in every state. Reset during MOD_WAIT drops modulo_start_o immediately; a late modulo_ready_i arriving in IDLE is ignored.
- IDLE: alu_mode_o = 3. On start_i = 1: A <= zahl_a_i, B <= zahl_b_i; clear ergebnis_o, error_o and iter_cnt_o; go to ORD_BIG. If start_i is low, stay in IDLE.
- ORD_BIG: op_a_o = A, op_b_o = B, alu_mode_o = 0. Capture alu_res_i into register BIG. Go to ORD_SMALL.
- ORD_SMALL: same operands, alu_mode_o = 1. Capture alu_res_i into register SMALL. Go to CHECK.
- CHECK: A <= BIG, B <= SMALL.
  - If SMALL == 0: ergebnis_o <= BIG, go to DONE. This gives gcd(x,0) = x and gcd(0,0) = 0.
  - Otherwise go to MOD_START.
- MOD_START: op_a_o = A, op_b_o = B, alu_mode_o = 2, modulo_start_o = 1 for exactly this cycle. Clear the timeout counter. Go to MOD_WAIT.
- MOD_WAIT: operands and alu_mode_o = 2 held stable; modulo_start_o = 0.
  - When modulo_ready_i = 1: R = alu_res_i, then A <= B, B <= R, iter_cnt_o increments (saturating). If R == 0, ergebnis_o <= B (the pre-update value) and go to DONE; otherwise go to MOD_START.
  - Else the timeout counter increments. When it reaches TIMEOUT_CYCLES - 1 without ready: error_o <= 1, ergebnis_o <= 0, go to DONE.
  - modulo_ready_i is never sampled in MOD_START, so a stale ready level from the previous operation is not consumed.
- DONE: valid_o = 1 for this single cycle, alu_mode_o = 3. Go to IDLE.
- start_i is ignored in every state except IDLE, including DONE.
- Latency: for a zero operand, valid_o is high in the 4th cycle after the accepting edge (ORD_BIG, ORD_SMALL, CHECK, DONE). Each modulo iteration adds 1 + (modulo latency) cycles.
- Operand order is irrelevant because of the ORD_BIG/ORD_SMALL steps.

Test Plan:
- A=48, B=18, ALU with real modulo unit -> ergebnis_o = 6, iter_cnt_o = 3, error_o = 0, valid_o a single-cycle pulse; exactly 3 modulo_start_o pulses.
- A=18, B=48 -> ergebnis_o = 6, iter_cnt_o = 3, same modulo_start_o count as the previous case.
- A=0, B=0 -> ergebnis_o = 0, iter_cnt_o = 0, valid_o 4 cycles after the start edge, no modulo_start_o. Then A=17, B=0 -> ergebnis_o = 17, same timing.
- A=65535, B=65534 -> ergebnis_o = 1, iter_cnt_o = 2. Also check that start_i pulses while busy_o = 1 change nothing.
- Modulo model holds ready low, TIMEOUT_CYCLES = 16 -> valid_o = 1 and error_o = 1 with ergebnis_o = 0, timed per the MOD_WAIT timeout rule. The next start (12, 8) -> ergebnis_o = 4, error_o = 0.
- rst asserted for one cycle in MOD_WAIT -> next cycle busy_o = 0, alu_mode_o = 3, all other outputs 0. A late modulo_ready_i arriving in IDLE causes no state change.
